// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: pipeline interlock controller for a 5-stage MIPS-style core.
// Detects load-use and jr operand hazards, sequences multi-cycle stalls through a
// small FSM (IDLE / STALL / MULDIV), and arbitrates flushes from taken branches
// and jumps. The multi-cycle mult/div tracking (MULDIV state, busy counter and
// MulDiv_Busy) is only built when HAZARD_MULDIV_EN is defined; otherwise those
// inputs are ignored and MulDiv_Busy is held low.
module hazard_stall_ctrl #(
  parameter int MULDIV_LATENCY = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] IFID_RegRsAddr,
  input  logic [4:0] IFID_RegRtAddr,
  input  logic       IFID_UsesRt,
  input  logic [1:0] IFID_PCSrc,
  input  logic       IFID_ReadsHiLo,
  input  logic       IFID_IsMulDiv,
  input  logic       IDEX_MemRead,
  input  logic       IDEX_RegWrite,
  input  logic       IDEX_MulDivStart,
  input  logic [4:0] IDEX_RegWrAddr,
  input  logic       EXMEM_MemRead,
  input  logic [4:0] EXMEM_RegWrAddr,
  input  logic       EX_BranchTaken,
  output logic       PC_Write,
  output logic       IFID_Write,
  output logic       IFID_Flush,
  output logic       IDEX_Flush,
  output logic       MulDiv_Busy,
  output logic [1:0] HazState
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_STALL  = 2'b01,
    ST_MULDIV = 2'b10
  } haz_state_t;

  localparam logic [1:0] PCSRC_JUMP  = 2'b01;
  localparam logic [1:0] PCSRC_JUMPR = 2'b10;

  haz_state_t state_reg;
  logic [1:0] stall_cnt_reg;

  logic load_use;
  logic rs_nonzero;
  logic jr_deep;
  logic jr_shallow;
  logic hazard_any;
  logic hazard_deep;
  logic muldiv_dep;
  logic stall;

  // Operand hazard detection against the instructions sitting in EX and MEM.
  always_comb begin
    rs_nonzero = (IFID_RegRsAddr != 5'd0);
    load_use   = IDEX_MemRead && (IDEX_RegWrAddr != 5'd0) &&
                 ((IDEX_RegWrAddr == IFID_RegRsAddr) ||
                  (IFID_UsesRt && (IDEX_RegWrAddr == IFID_RegRtAddr)));
    // jr resolves its target in ID, so a load still in EX costs two bubbles,
    // while an ALU result in EX or a load in MEM costs one.
    jr_deep    = (IFID_PCSrc == PCSRC_JUMPR) && rs_nonzero &&
                 IDEX_RegWrite && IDEX_MemRead &&
                 (IDEX_RegWrAddr == IFID_RegRsAddr);
    jr_shallow = (IFID_PCSrc == PCSRC_JUMPR) && rs_nonzero &&
                 ((IDEX_RegWrite && !IDEX_MemRead &&
                   (IDEX_RegWrAddr == IFID_RegRsAddr)) ||
                  (EXMEM_MemRead && (EXMEM_RegWrAddr == IFID_RegRsAddr)));
    hazard_deep = jr_deep;
    hazard_any  = load_use || jr_deep || jr_shallow;
  end

`ifdef HAZARD_MULDIV_EN
  logic [5:0] busy_cnt_reg;
  logic       busy_reg;

  // The ID instruction must wait for the HI/LO unit if it reads or reuses it.
  assign muldiv_dep  = IFID_ReadsHiLo || IFID_IsMulDiv;
  assign MulDiv_Busy = busy_reg;
`else
  logic unused_muldiv;

  assign muldiv_dep    = 1'b0;
  assign MulDiv_Busy   = 1'b0;
  assign unused_muldiv = ^{IDEX_MulDivStart, IFID_ReadsHiLo, IFID_IsMulDiv};
`endif

  // Decide whether the front end must hold this cycle, based on FSM state.
  always_comb begin
    stall = 1'b0;
    case (state_reg)
      ST_STALL:  stall = 1'b1;
      ST_MULDIV: stall = muldiv_dep || hazard_any;
      default:   stall = hazard_any;
    endcase
  end

  // Pipeline control outputs: reset, then taken branch, then stall, then jump.
  always_comb begin
    PC_Write   = 1'b1;
    IFID_Write = 1'b1;
    IFID_Flush = 1'b0;
    IDEX_Flush = 1'b0;
    if (reset) begin
      PC_Write   = 1'b1;
      IFID_Write = 1'b1;
    end else if (EX_BranchTaken) begin
      IFID_Flush = 1'b1;
      IDEX_Flush = 1'b1;
    end else if (stall) begin
      PC_Write   = 1'b0;
      IFID_Write = 1'b0;
      IDEX_Flush = 1'b1;
    end else begin
      IFID_Flush = (IFID_PCSrc == PCSRC_JUMP);
    end
  end

  // Stall / mult-div sequencing FSM with its counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      stall_cnt_reg <= 2'd0;
`ifdef HAZARD_MULDIV_EN
      busy_cnt_reg  <= 6'd0;
      busy_reg      <= 1'b0;
`endif
    end else begin
      case (state_reg)
        ST_STALL: begin
          // A taken branch squashes the stalled instruction, so stop waiting.
          if (EX_BranchTaken || (stall_cnt_reg <= 2'd1)) begin
            state_reg     <= ST_IDLE;
            stall_cnt_reg <= 2'd0;
          end else begin
            stall_cnt_reg <= stall_cnt_reg - 2'd1;
          end
        end
`ifdef HAZARD_MULDIV_EN
        ST_MULDIV: begin
          // The unit keeps running regardless of branches; leave when it drains.
          if (busy_cnt_reg <= 6'd1) begin
            state_reg    <= ST_IDLE;
            busy_cnt_reg <= 6'd0;
            busy_reg     <= 1'b0;
          end else begin
            busy_cnt_reg <= busy_cnt_reg - 6'd1;
          end
        end
`endif
        default: begin
          state_reg     <= ST_IDLE;
          stall_cnt_reg <= 2'd0;
`ifdef HAZARD_MULDIV_EN
          if (IDEX_MulDivStart) begin
            state_reg    <= ST_MULDIV;
            busy_cnt_reg <= 6'(MULDIV_LATENCY - 1);
            busy_reg     <= 1'b1;
          end else
`endif
          if (!EX_BranchTaken && hazard_deep) begin
            state_reg     <= ST_STALL;
            stall_cnt_reg <= 2'd1;
          end
        end
      endcase
    end
  end

  assign HazState = state_reg;

endmodule

// File: doc/hazard_stall_ctrl.md
HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 SHALL provide parameter MULDIV_LATENCY, default 32: total EX occupancy in cycles of a mult/div operation, legal range 2..63.
REQ-002 SHALL have port clk, input, 1: sole clock, all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have inputs IFID_RegRsAddr and IFID_RegRtAddr, 5 each: source registers of the ID-stage instruction.
REQ-005 SHALL have inputs IFID_UsesRt (1: rt is a read operand), IFID_PCSrc (2: 00 PC+4, 01 Jump, 10 JumpR, 11 Branch), IFID_ReadsHiLo (1: mfhi/mflo) and IFID_IsMulDiv (1).
REQ-006 SHALL have inputs IDEX_MemRead, IDEX_RegWrite and IDEX_MulDivStart (1 each), plus IDEX_RegWrAddr (5).
REQ-007 SHALL have inputs EXMEM_MemRead (1), EXMEM_RegWrAddr (5) and EX_BranchTaken (1: branch resolved taken in EX).
REQ-008 SHALL have outputs PC_Write, IFID_Write, IFID_Flush and IDEX_Flush (1 each); MulDiv_Busy (1, registered); and HazState (2, registered).

Function
REQ-009 SHALL encode HazState as IDLE=00, STALL=01, MULDIV=10; value 11 SHALL be unreachable and decode as IDLE.
REQ-010 SHALL flag a load-use hazard when IDEX_MemRead=1, IDEX_RegWrAddr!=0, and IDEX_RegWrAddr equals IFID_RegRsAddr, or equals IFID_RegRtAddr with IFID_UsesRt=1.
REQ-011 SHALL flag a JumpR hazard of depth 2 when IFID_PCSrc=10, IDEX_RegWrite=1, IDEX_MemRead=1 and IDEX_RegWrAddr==IFID_RegRsAddr!=0.
REQ-012 SHALL flag a JumpR hazard of depth 1 when IFID_PCSrc=10 and either (IDEX_RegWrite=1, IDEX_MemRead=0, IDEX_RegWrAddr==IFID_RegRsAddr!=0) or (EXMEM_MemRead=1, EXMEM_RegWrAddr==IFID_RegRsAddr!=0).
REQ-013 A load-use hazard SHALL have depth 1; when several hazards coincide, the largest depth SHALL apply.
REQ-014 "Stall" SHALL mean PC_Write=0, IFID_Write=0, IDEX_Flush=1, IFID_Flush=0; "no stall" SHALL mean PC_Write=1 and IFID_Write=1.
REQ-015 In IDLE, a hazard of depth N SHALL stall in the same cycle; if N=2, the FSM SHALL enter STALL with the stall counter set to 1.
REQ-016 In STALL, the FSM SHALL stall, decrement the counter, and return to IDLE on the edge where the counter reaches 0.
REQ-017 In IDLE, IDEX_MulDivStart=1 SHALL load the busy counter with MULDIV_LATENCY-1 and enter MULDIV with MulDiv_Busy=1 from the next cycle.
REQ-018 In MULDIV, the FSM SHALL stall only when IFID_ReadsHiLo=1 or IFID_IsMulDiv=1, and SHALL decrement the busy counter every cycle.
REQ-019 When the busy counter is 0, the FSM SHALL return to IDLE and clear MulDiv_Busy on that edge.
REQ-020 In MULDIV, load-use and JumpR hazards SHALL also be evaluated with depth 1 (no nested STALL state).
REQ-021 EX_BranchTaken=1 SHALL force IFID_Flush=1, IDEX_Flush=1, PC_Write=1 and IFID_Write=1, overriding any stall, and SHALL abort STALL to IDLE.
REQ-022 EX_BranchTaken=1 SHALL NOT abort MULDIV or alter its counter.
REQ-023 IFID_PCSrc=01 with no stall and no taken branch SHALL assert IFID_Flush=1 for that cycle.
REQ-024 Priority SHALL be: reset > EX_BranchTaken > stall (MULDIV/STALL/hazard) > Jump flush.

Reset
REQ-025 While reset=1, HazState SHALL be IDLE, both counters 0 and MulDiv_Busy 0, asynchronously.
REQ-026 While reset=1, PC_Write and IFID_Write SHALL be 1 and both flush outputs SHALL be 0.
REQ-027 Reset asserted mid-STALL or mid-MULDIV SHALL discard the pending count; no stall SHALL persist after deassertion.

Configuration
REQ-028 With macro HAZARD_MULDIV_EN defined, the MULDIV state, busy counter and MulDiv_Busy behaviour SHALL be present.
REQ-029 Without HAZARD_MULDIV_EN, IDEX_MulDivStart, IFID_ReadsHiLo and IFID_IsMulDiv SHALL be ignored, MULDIV SHALL be unreachable, and MulDiv_Busy SHALL be tied 0.

Verification
REQ-030 lw $8 in IDEX, ID add uses $8 as rs -> exactly 1 stall cycle, IDEX_Flush=1, then HazState stays IDLE.
REQ-031 lw $9 in IDEX, ID jr $9 -> 2 consecutive stall cycles with HazState=01 in the second, then PC_Write=1.
REQ-032 mult starts with MULDIV_LATENCY=4, followed by mflo in ID -> MulDiv_Busy=1 for 3 cycles and mflo stalled until the busy counter reaches 0.
REQ-033 STALL active and EX_BranchTaken=1 -> same cycle IFID_Flush=1, IDEX_Flush=1, PC_Write=1; next cycle HazState=IDLE.
REQ-034 Writer reg $0 with a lw in IDEX and rs=0 in ID -> no stall; j in ID -> IFID_Flush=1 for one cycle.
REQ-035 Reset pulsed during MULDIV with the busy counter at 20 -> HazState=00 and MulDiv_Busy=0 immediately, with no stall after release.
